ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter and sequencer for the single-port 256-word data RAM. It lets the instruction-fetch port (read-only) and the load/store data port share one RAM. It grants one request at a time using round-robin priority, drives the RAM's enable/address/data lines from registered values, and returns read data with a one-cycle response pulse. Out-of-range and misaligned addresses are rejected with an error response and never reach the RAM.

## Interface
Parameters:
- ADDR_LIMIT_BIT, 10, address bits [31:ADDR_LIMIT_BIT] must be zero; otherwise the access is an out-of-range error.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- i_req  input  1  instruction-port request; held high until accepted.
- i_addr  input  32  instruction byte address.
- i_ready  output  1  combinational; high in the cycle the instruction request is accepted.
- i_rvalid  output  1  one-cycle instruction response strobe.
- i_rdata  output  32  instruction read data; valid with i_rvalid, otherwise 0.
- i_err  output  1  with i_rvalid: access rejected.
- d_req  input  1  data-port request; held high until accepted.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  32  data byte address.
- d_wdata  input  32  write data.
- d_ready  output  1  combinational; high in the cycle the data request is accepted.
- d_rvalid  output  1  one-cycle data response strobe; also issued for writes.
- d_rdata  output  32  data read data; 0 for writes and errors.
- d_err  output  1  with d_rvalid: access rejected.
- ram_writeEnable  output  1  to RAM writeEnable.
- ram_readEnable  output  1  to RAM readEnable.
- ram_address  output  32  to RAM address (RAM decodes bits [9:2]).
- ram_dataIn  output  32  to RAM dataIn.
- ram_dataOut  input  32  from RAM dataOut (combinational read).

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- Acceptance is possible in IDLE and RESP:
  - If only one port requests, that port is granted.
  - If both request, the port not granted last is granted.
  - last_grant resets to INSTR, so the data port wins the first tie.
- On the acceptance posedge, the arbiter latches the granted port, we (forced to 0 for the instruction port), address, wdata and an error flag, then moves to ACCESS.
  - err = addr[1:0]≠0, or addr[31:ADDR_LIMIT_BIT]≠0.
- ACCESS:
  - ram_address and ram_dataIn are driven from the latched values.
  - ram_readEnable = !we & !err; ram_writeEnable = we & !err.
  - The RAM writes on the negedge inside this cycle.
  - At the closing posedge, ram_dataOut (or 0 if we or err) is captured into the response register. The FSM then moves to RESP.
- RESP: the granted port's rvalid is high, with rdata and err from the response register.
  - If a request is accepted this cycle, the next state is ACCESS; otherwise IDLE.
- Outside ACCESS, the RAM enables are 0, and ram_address/ram_dataIn hold their last latched value.
- i_ready/d_ready are never asserted in ACCESS. At most one ready is high per cycle.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, last_grant INSTR, latched registers 0.
- Reset assertion is immediate (asynchronous). Reset during ACCESS drops ram_writeEnable before the negedge, so the pending write is discarded.
- No rvalid is issued for a transaction cut off by reset.
- Latency:
  - Accepted at posedge edge N (ready high in the cycle ending at N).
  - RAM access in cycle N..N+1.
  - rvalid high in cycle N+1..N+2.
- Throughput: one transaction per 2 cycles (back-to-back via RESP→ACCESS).
- Simultaneous requests always alternate grants. A requester waits at most one transaction.
- A request dropped before ready is simply never served; no state is kept.
- An error access still takes ACCESS and RESP cycles (fixed latency), with RAM enables low.

## Test plan
- Reset, then a single d write: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF → d_ready next cycle; ram_writeEnable=1 for one cycle at address 0x10; d_rvalid=1, d_err=0 two cycles later.
- Read-back: i_req with i_addr=0x10 after the above write → i_rvalid=1, i_rdata=0xDEADBEEF, i_err=0, exactly 2 cycles after acceptance.
- Contention: i_req and d_req held high together for 8 cycles after reset → grants D,I,D,I…; each port gets 2 responses; i_ready/d_ready never both high.
- Errors:
  - d_addr=0x12 (misaligned) → d_err=1, d_rdata=0, no RAM enable.
  - d_addr=0x400 (out of range) → d_err=1, RAM content at 0x0 unchanged.
- Reset mid-write: reset pulled low during the ACCESS cycle before the negedge → ram_writeEnable falls immediately, target word unchanged, no d_rvalid, FSM in IDLE after release.
- Back-to-back reads: d_req held with new d_addr every acceptance → d_ready is asserted every 2 cycles (accepted in RESP), and responses arrive in order with the correct data.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter/sequencer sharing one 256-word RAM between fetch and load/store ports
// Requests are latched on acceptance, the RAM is driven for one ACCESS cycle, and a response strobe follows in RESP.
module ram_arbiter #(
  parameter int ADDR_LIMIT_BIT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        ram_writeEnable,
  output logic        ram_readEnable,
  output logic [31:0] ram_address,
  output logic [31:0] ram_dataIn,
  input  logic [31:0] ram_dataOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] resp_q, resp_d;

  logic        can_accept;
  logic        pick_d;
  logic        pick_i;
  logic        accept;
  logic [31:0] req_addr;
  logic        req_err;
  logic        resp_valid;

  // On a tie the data port wins unless it was the one granted last.
  always_comb begin
    can_accept = (state_q != ACCESS);
    pick_d     = d_req & (~i_req | (last_grant_q == PORT_I));
    pick_i     = i_req & ~pick_d;
    d_ready    = can_accept & pick_d;
    i_ready    = can_accept & pick_i;
    accept     = i_ready | d_ready;
    req_addr   = d_ready ? d_addr : i_addr;
    req_err    = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_LIMIT_BIT] != '0);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_d       = resp_q;

    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS: begin
        resp_d  = (we_q || err_q) ? 32'h0 : ram_dataOut;
        state_d = RESP;
      end
      RESP:    state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      last_grant_d = d_ready;
      port_d       = d_ready;
      we_d         = d_ready & d_we;
      err_d        = req_err;
      addr_d       = req_addr;
      wdata_d      = d_ready ? d_wdata : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_I;
      port_q       <= PORT_I;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      resp_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_q       <= resp_d;
    end
  end

  // Enables are decoded from state so an asynchronous reset drops them at once.
  always_comb begin
    ram_address     = addr_q;
    ram_dataIn      = wdata_q;
    ram_readEnable  = (state_q == ACCESS) & ~we_q & ~err_q;
    ram_writeEnable = (state_q == ACCESS) & we_q & ~err_q;
    resp_valid      = (state_q == RESP);
    i_rvalid        = resp_valid & (port_q == PORT_I);
    d_rvalid        = resp_valid & (port_q == PORT_D);
    i_rdata         = i_rvalid ? resp_q : 32'h0;
    d_rdata         = d_rvalid ? resp_q : 32'h0;
    i_err           = i_rvalid & err_q;
    d_err           = d_rvalid & err_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scenario tasks plus an in-order response scoreboard for ram_arbiter
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        ram_writeEnable, ram_readEnable;
  logic [31:0] ram_address, ram_dataIn, ram_dataOut;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] mem[256];
  logic [31:0] ref_mem[256];
  logic        mem_init;
  logic        ref_init;

  ram_arbiter #(.ADDR_LIMIT_BIT(10)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_writeEnable(ram_writeEnable), .ram_readEnable(ram_readEnable),
    .ram_address(ram_address), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(int i);
    return {16'hA5A5, 8'(i), 8'(~i)};
  endfunction

  // RAM stand-in: negedge write, combinational read on address bits [9:2].
  always @(negedge clk) begin
    if (mem_init !== 1'b1) begin
      for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
      mem_init <= 1'b1;
    end else if (ram_writeEnable === 1'b1) begin
      mem[ram_address[9:2]] <= ram_dataIn;
    end
  end
  assign ram_dataOut = mem[ram_address[9:2]];

  // Scoreboard: push on acceptance, pop and check on each response strobe.
  always @(negedge clk) begin
    txn_t        e;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [31:0] got_data;
    logic        got_err;
    if (ref_init !== 1'b1) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
      ref_init = 1'b1;
    end
    if (reset === 1'b1) begin
      if (i_rvalid === 1'b1 || d_rvalid === 1'b1) begin
        n_checks++;
        if (i_rvalid === 1'b1 && d_rvalid === 1'b1) begin
          n_fail++;
          $display("FAIL both_rvalid: i_rvalid=%b d_rvalid=%b, required at most one", i_rvalid, d_rvalid);
        end
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rvalid: response with empty scoreboard");
        end else begin
          e        = sb.pop_front();
          exp_err  = (e.addr[1:0] != 2'b00) || (e.addr[31:10] != 22'h0);
          exp_data = (e.we || exp_err) ? 32'h0 : ref_mem[e.addr[9:2]];
          if (e.we && !exp_err) ref_mem[e.addr[9:2]] = e.wdata;
          n_checks++;
          if ((e.port ? d_rvalid : i_rvalid) !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_port: got port %b, required %b", d_rvalid, e.port);
          end
          got_data = e.port ? d_rdata : i_rdata;
          got_err  = e.port ? d_err : i_err;
          n_checks++;
          if (got_data !== exp_data || got_err !== exp_err) begin
            n_fail++;
            $display("FAIL resp_data addr=%h: got data=%h err=%b, required data=%h err=%b",
                     e.addr, got_data, got_err, exp_data, exp_err);
          end
        end
      end
      n_checks++;
      if (i_ready === 1'b1 && d_ready === 1'b1) begin
        n_fail++;
        $display("FAIL ready_exclusive: i_ready=1 d_ready=1, required at most one");
      end
      if (i_ready === 1'b1) sb.push_back('{1'b0, 1'b0, i_addr, 32'h0});
      if (d_ready === 1'b1) sb.push_back('{1'b1, d_we, d_addr, d_wdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) tick();
    sb.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (2) tick();
    n_checks++;
    if ({i_ready, i_rvalid, i_rdata, i_err, d_ready, d_rvalid, d_rdata, d_err,
         ram_writeEnable, ram_readEnable, ram_address, ram_dataIn} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: some output nonzero during reset (addr=%h din=%h), required all 0",
               ram_address, ram_dataIn);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({i_rvalid, d_rvalid, ram_writeEnable, ram_readEnable, ram_address} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: outputs nonzero after release, required 0");
    end
  endtask

  task automatic test_single_write();
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ready: d_ready=%b i_ready=%b, required 1/0", d_ready, i_ready);
    end
    tick();
    d_req = 0; d_we = 0;
    n_checks++;
    if (ram_writeEnable !== 1'b1 || ram_readEnable !== 1'b0 || ram_address !== 32'h10 ||
        ram_dataIn !== 32'hDEADBEEF || d_rvalid !== 1'b0 || d_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_access: we=%b re=%b addr=%h din=%h rvalid=%b, required 1 0 10 deadbeef 0",
               ram_writeEnable, ram_readEnable, ram_address, ram_dataIn, d_rvalid);
    end
    tick();
    n_checks++;
    if (ram_writeEnable !== 1'b0 || d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_resp: we=%b rvalid=%b err=%b rdata=%h, required 0 1 0 0",
               ram_writeEnable, d_rvalid, d_err, d_rdata);
    end
    n_checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_mem: mem[4]=%h, required deadbeef", mem[4]);
    end
    tick();
    n_checks++;
    if (d_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_single_pulse: d_rvalid=%b, required 0", d_rvalid);
    end
  endtask

  task automatic test_readback();
    i_req = 1; i_addr = 32'h10;
    #1;
    n_checks++;
    if (i_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rb_ready: i_ready=%b, required 1", i_ready);
    end
    tick();
    i_req = 0;
    n_checks++;
    if (ram_readEnable !== 1'b1 || i_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_access: re=%b rvalid=%b, required 1 0", ram_readEnable, i_rvalid);
    end
    tick();
    n_checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEADBEEF || i_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_resp: rvalid=%b rdata=%h err=%b, required 1 deadbeef 0", i_rvalid, i_rdata, i_err);
    end
    tick();
  endtask

  task automatic test_contention();
    logic exp_g[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic got_g[4];
    int   ng = 0, ni = 0, nd = 0;
    apply_reset();
    i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) begin i_req = 0; d_req = 0; end
      #1;
      if (i_ready === 1'b1 || d_ready === 1'b1) begin
        if (ng < 4) got_g[ng] = d_ready;
        ng++;
      end
      if (i_rvalid === 1'b1) ni++;
      if (d_rvalid === 1'b1) nd++;
      tick();
    end
    n_checks++;
    if (ng !== 4) begin
      n_fail++;
      $display("FAIL cont_grants: %0d grants, required 4", ng);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got_g[k] !== exp_g[k]) begin
        n_fail++;
        $display("FAIL cont_order[%0d]: granted d=%b, required d=%b", k, got_g[k], exp_g[k]);
      end
    end
    n_checks++;
    if (ni !== 2 || nd !== 2) begin
      n_fail++;
      $display("FAIL cont_resps: i=%0d d=%0d, required 2 and 2", ni, nd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] old0;
    d_req = 1; d_we = 0; d_addr = 32'h12;
    tick();
    d_req = 0;
    n_checks++;
    if (ram_readEnable !== 1'b0 || ram_writeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_enables: re=%b we=%b, required 0 0", ram_readEnable, ram_writeEnable);
    end
    tick();
    n_checks++;
    if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mis_resp: rvalid=%b err=%b rdata=%h, required 1 1 0", d_rvalid, d_err, d_rdata);
    end
    tick();
    old0 = mem[0];
    d_req = 1; d_we = 1; d_addr = 32'h400; d_wdata = 32'h12345678;
    tick();
    d_req = 0; d_we = 0;
    n_checks++;
    if (ram_writeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_enable: we=%b, required 0", ram_writeEnable);
    end
    tick();
    n_checks++;
    if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL oor_resp: rvalid=%b err=%b rdata=%h, required 1 1 0", d_rvalid, d_err, d_rdata);
    end
    tick();
    n_checks++;
    if (mem[0] !== old0) begin
      n_fail++;
      $display("FAIL oor_mem: mem[0]=%h, required %h", mem[0], old0);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] old;
    int          nrv = 0;
    old = mem[12];
    d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
    tick();
    d_req = 0; d_we = 0;
    n_checks++;
    if (ram_writeEnable !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: we=%b, required 1 in ACCESS", ram_writeEnable);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (ram_writeEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_we_drop: we=%b, required 0", ram_writeEnable);
    end
    tick();
    sb.delete();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (d_rvalid === 1'b1) nrv++;
      tick();
    end
    n_checks++;
    if (nrv !== 0) begin
      n_fail++;
      $display("FAIL rst_no_rvalid: %0d strobes, required 0", nrv);
    end
    n_checks++;
    if (mem[12] !== old) begin
      n_fail++;
      $display("FAIL rst_mem: mem[12]=%h, required %h", mem[12], old);
    end
    i_req = 1; i_addr = 32'h0; d_req = 1; d_addr = 32'h30;
    #1;
    n_checks++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle: d_ready=%b i_ready=%b, required 1 0", d_ready, i_ready);
    end
    tick();
    i_req = 0; d_req = 0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs[5] = '{32'h10, 32'h44, 32'h30, 32'h3FC, 32'h100};
    int k = 0, cyc = 0, last = 0;
    d_req = 1; d_we = 0; d_addr = addrs[0];
    while (k < 5 && cyc < 40) begin
      #1;
      if (d_ready === 1'b1) begin
        if (k > 0) begin
          n_checks++;
          if (cyc - last !== 2) begin
            n_fail++;
            $display("FAIL b2b_interval[%0d]: %0d cycles, required 2", k, cyc - last);
          end
        end
        last = cyc;
        k++;
        tick();
        if (k < 5) d_addr = addrs[k];
        else d_req = 0;
      end else begin
        tick();
      end
      cyc++;
    end
    d_req = 0;
    n_checks++;
    if (k !== 5) begin
      n_fail++;
      $display("FAIL b2b_accepts: %0d accepted within bound, required 5", k);
    end
    repeat (4) tick();
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_readback();
    test_contention();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
